// File: rtl/cc_sevenseg_pkg.sv
// rtl/cc_sevenseg_pkg.sv - glyph constants and sizing helpers for the seven-segment scanner
package cc_sevenseg_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    function automatic int presc_width(input int dig_ticks);
        return $clog2(dig_ticks);
    endfunction

endpackage

// File: rtl/cc_sevenseg_decode.sv
// rtl/cc_sevenseg_decode.sv - nibble to active-low seven-segment glyph
module cc_sevenseg_decode
    import cc_sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_i,
    input  logic       dark_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_OFF;
        if (!dark_i) begin
            case (nibble_i)
                4'h0: glyph_o = GLYPH_0;
                4'h1: glyph_o = GLYPH_1;
                4'h2: glyph_o = GLYPH_2;
                4'h3: glyph_o = GLYPH_3;
                4'h4: glyph_o = GLYPH_4;
                4'h5: glyph_o = GLYPH_5;
                4'h6: glyph_o = GLYPH_6;
                4'h7: glyph_o = GLYPH_7;
                4'h8: glyph_o = GLYPH_8;
                4'h9: glyph_o = GLYPH_9;
                4'hA: glyph_o = hex_i ? GLYPH_A : SEG_DASH;
                4'hB: glyph_o = hex_i ? GLYPH_B : SEG_DASH;
                4'hC: glyph_o = hex_i ? GLYPH_C : SEG_DASH;
                4'hD: glyph_o = hex_i ? GLYPH_D : SEG_DASH;
                4'hE: glyph_o = hex_i ? GLYPH_E : SEG_DASH;
                default: glyph_o = hex_i ? GLYPH_F : SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/cc_sevenseg_scan.sv
// rtl/cc_sevenseg_scan.sv - multiplexed seven-segment scanner with frame-aligned shadow load
module cc_sevenseg_scan
    import cc_sevenseg_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int DIG_TICKS     = 12500,
    parameter int BLINK_FRAMES  = 50,
    parameter int AN_ACTIVE_LOW = 0
) (
    input  logic              CC_SEVENSEG_SCAN_CLOCK_50,
    input  logic              CC_SEVENSEG_SCAN_RESET_InHigh,
    input  logic [4*NDIG-1:0] CC_SEVENSEG_SCAN_data,
    input  logic [NDIG-1:0]   CC_SEVENSEG_SCAN_dp,
    input  logic [NDIG-1:0]   CC_SEVENSEG_SCAN_blank,
    input  logic [NDIG-1:0]   CC_SEVENSEG_SCAN_blink,
    input  logic              CC_SEVENSEG_SCAN_hex,
    input  logic              CC_SEVENSEG_SCAN_lzs,
    input  logic              CC_SEVENSEG_SCAN_load,
    output logic              CC_SEVENSEG_SCAN_ack,
    output logic [6:0]        CC_SEVENSEG_SCAN_seg,
    output logic              CC_SEVENSEG_SCAN_dpo,
    output logic [NDIG-1:0]   CC_SEVENSEG_SCAN_an,
    output logic              CC_SEVENSEG_SCAN_frame
);

    localparam int PW = presc_width(DIG_TICKS);
    localparam int IW = $clog2(NDIG);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int SW = 7 * NDIG + 2;

    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIG_TICKS - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
    localparam logic [FW-1:0]   FC_LAST    = FW'(BLINK_FRAMES - 1);
    localparam logic [NDIG-1:0] AN_FLIP    = (AN_ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};
    // Config word layout: {lzs, hex, blink, blank, dp, data}; reset leaves every digit blanked.
    localparam logic [SW-1:0]   CFG_RST    = {2'b00, {NDIG{1'b0}}, {NDIG{1'b1}},
                                              {NDIG{1'b0}}, {(4*NDIG){1'b0}}};

    logic [PW-1:0]   presc_q, presc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            bphase_q, bphase_d;
    logic            pending_q, pending_d;
    logic            ack_q, frame_q;
    logic [SW-1:0]   stg_q, stg_d;
    logic [SW-1:0]   act_q, act_d;
    logic [6:0]      seg_q;
    logic            dpo_q;
    logic [NDIG-1:0] an_q;

    logic            tc, boundary;
    logic [4*NDIG-1:0] a_data;
    logic [NDIG-1:0] a_dp, a_blank, a_blink;
    logic            a_hex, a_lzs;
    logic [NDIG-1:0] dark_vec, an_d;
    logic            run_zero;
    logic [3:0]      cur_nib;
    logic            cur_dark, cur_dp;
    logic [6:0]      glyph;

    always_comb begin
        tc        = (presc_q == PRESC_LAST);
        boundary  = tc && (idx_q == IDX_LAST);
        presc_d   = tc ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        fcnt_d    = fcnt_q;
        bphase_d  = bphase_q;
        if (boundary) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d   = '0;
                bphase_d = ~bphase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        // A load on the boundary cycle lands in staging after the copy, so it waits a frame.
        stg_d     = CC_SEVENSEG_SCAN_load
                    ? {CC_SEVENSEG_SCAN_lzs, CC_SEVENSEG_SCAN_hex, CC_SEVENSEG_SCAN_blink,
                       CC_SEVENSEG_SCAN_blank, CC_SEVENSEG_SCAN_dp, CC_SEVENSEG_SCAN_data}
                    : stg_q;
        pending_d = CC_SEVENSEG_SCAN_load || (pending_q && !boundary);
        act_d     = (boundary && pending_q) ? stg_q : act_q;
    end

    assign a_data  = act_d[4*NDIG-1:0];
    assign a_dp    = act_d[5*NDIG-1:4*NDIG];
    assign a_blank = act_d[6*NDIG-1:5*NDIG];
    assign a_blink = act_d[7*NDIG-1:6*NDIG];
    assign a_hex   = act_d[7*NDIG];
    assign a_lzs   = act_d[7*NDIG+1];

    // Outputs are registered from next-state values so they track the new slot/frame on the edge.
    always_comb begin
        run_zero = 1'b1;
        dark_vec = '0;
        an_d     = '0;
        cur_nib  = 4'h0;
        cur_dark = 1'b1;
        cur_dp   = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            run_zero    = run_zero && (a_data[4*i +: 4] == 4'h0);
            dark_vec[i] = a_blank[i] || (a_blink[i] && bphase_d) || (a_lzs && run_zero && (i != 0));
        end
        for (int i = 0; i < NDIG; i++) begin
            if (idx_d == IW'(i)) begin
                an_d[i]  = 1'b1;
                cur_nib  = a_data[4*i +: 4];
                cur_dark = dark_vec[i];
                cur_dp   = a_dp[i];
            end
        end
    end

    cc_sevenseg_decode u_decode (
        .nibble_i (cur_nib),
        .hex_i    (a_hex),
        .dark_i   (cur_dark),
        .glyph_o  (glyph)
    );

    always_ff @(posedge CC_SEVENSEG_SCAN_CLOCK_50 or posedge CC_SEVENSEG_SCAN_RESET_InHigh) begin
        if (CC_SEVENSEG_SCAN_RESET_InHigh) begin
            presc_q   <= '0;
            idx_q     <= '0;
            fcnt_q    <= '0;
            bphase_q  <= 1'b0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            frame_q   <= 1'b0;
            stg_q     <= CFG_RST;
            act_q     <= CFG_RST;
            seg_q     <= SEG_OFF;
            dpo_q     <= 1'b1;
            an_q      <= AN_FLIP;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            fcnt_q    <= fcnt_d;
            bphase_q  <= bphase_d;
            pending_q <= pending_d;
            ack_q     <= boundary && pending_q;
            frame_q   <= boundary;
            stg_q     <= stg_d;
            act_q     <= act_d;
            seg_q     <= glyph;
            dpo_q     <= cur_dark || !cur_dp;
            an_q      <= an_d ^ AN_FLIP;
        end
    end

    assign CC_SEVENSEG_SCAN_ack   = ack_q;
    assign CC_SEVENSEG_SCAN_seg   = seg_q;
    assign CC_SEVENSEG_SCAN_dpo   = dpo_q;
    assign CC_SEVENSEG_SCAN_an    = an_q;
    assign CC_SEVENSEG_SCAN_frame = frame_q;

endmodule

// File: tb/tb_cc_sevenseg_scan.sv
// tb/tb_cc_sevenseg_scan.sv - self-checking bench for cc_sevenseg_scan
module tb_cc_sevenseg_scan;

    typedef struct packed {
        logic        lzs;
        logic        hex;
        logic [3:0]  blink;
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [15:0] data;
    } cfg_t;

    localparam cfg_t CFG_RST = '{1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_data = '0;
    logic [3:0]  d_dp = '0, d_blank = '0, d_blink = '0;
    logic        d_hex = 1'b0, d_lzs = 1'b0, d_load = 1'b0;
    logic        ack, dpo, frame;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int frame_cnt = 0;

    int   n = 0;
    bit   pend = 1'b0;
    bit   m_frame = 1'b0, m_ack = 1'b0;
    cfg_t stg = CFG_RST, act = CFG_RST;

    always #5 clk = ~clk;

    cc_sevenseg_scan #(
        .NDIG(4), .DIG_TICKS(4), .BLINK_FRAMES(2), .AN_ACTIVE_LOW(0)
    ) dut (
        .CC_SEVENSEG_SCAN_CLOCK_50     (clk),
        .CC_SEVENSEG_SCAN_RESET_InHigh (rst),
        .CC_SEVENSEG_SCAN_data         (d_data),
        .CC_SEVENSEG_SCAN_dp           (d_dp),
        .CC_SEVENSEG_SCAN_blank        (d_blank),
        .CC_SEVENSEG_SCAN_blink        (d_blink),
        .CC_SEVENSEG_SCAN_hex          (d_hex),
        .CC_SEVENSEG_SCAN_lzs          (d_lzs),
        .CC_SEVENSEG_SCAN_load         (d_load),
        .CC_SEVENSEG_SCAN_ack          (ack),
        .CC_SEVENSEG_SCAN_seg          (seg),
        .CC_SEVENSEG_SCAN_dpo          (dpo),
        .CC_SEVENSEG_SCAN_an           (an),
        .CC_SEVENSEG_SCAN_frame        (frame)
    );

    function automatic logic [6:0] glyph(input logic [3:0] v, input logic hx);
        if (!hx && v > 4'd9) return 7'b0111111;
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] actual, input logic [7:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%h required=%h n=%0d t=%0t", name, actual, required, n, $time);
        end
    endtask

    // Model: n = clock edges since reset release; a frame is 16 edges, a slot 4 edges.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            n = 0; pend = 1'b0; stg = CFG_RST; act = CFG_RST;
            m_frame = 1'b0; m_ack = 1'b0;
        end else begin
            bit bnd;
            bnd     = (n % 16) == 15;
            m_frame = bnd;
            m_ack   = bnd && pend;
            if (bnd && pend) begin
                act  = stg;
                pend = 1'b0;
            end
            if (d_load) begin
                stg  = '{d_lzs, d_hex, d_blink, d_blank, d_dp, d_data};
                pend = 1'b1;
            end
            n++;
        end
    end

    initial forever begin
        @(negedge clk);
        begin
            logic [6:0] es;
            logic       edp;
            logic [3:0] ean, nib;
            int         slot, phase;
            bit         dark;
            if (rst || n == 0) begin
                es = 7'h7F; edp = 1'b1; ean = 4'h0;
            end else begin
                slot  = (n / 4) % 4;
                phase = ((n / 16) / 2) % 2;
                nib   = 4'(act.data >> (4 * slot));
                dark  = act.blank[slot] || (act.blink[slot] && phase == 1) ||
                        (act.lzs && slot != 0 && (act.data >> (4 * slot)) == 16'h0);
                es    = dark ? 7'h7F : glyph(nib, act.hex);
                edp   = dark || !act.dp[slot];
                ean   = 4'(1 << slot);
            end
            chk("seg", {1'b0, seg}, {1'b0, es});
            chk("dpo", {7'b0, dpo}, {7'b0, edp});
            chk("an", {4'b0, an}, {4'b0, ean});
            chk("frame", {7'b0, frame}, {7'b0, (!rst && m_frame)});
            chk("ack", {7'b0, ack}, {7'b0, (!rst && m_ack)});
            if (ack === 1'b1) ack_cnt++;
            if (frame === 1'b1) frame_cnt++;
        end
    end

    task automatic do_load(input logic [15:0] dv, input logic [3:0] dpv, input logic [3:0] bl,
                           input logic [3:0] bk, input logic hx, input logic lz);
        @(posedge clk); #1;
        d_data = dv; d_dp = dpv; d_blank = bl; d_blink = bk; d_hex = hx; d_lzs = lz; d_load = 1'b1;
        @(posedge clk); #1;
        d_load = 1'b0;
    endtask

    task automatic wait_n(input int target);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (n == target) return;
        end
        chk("wait_n_timeout", 8'd1, 8'd0);
    endtask

    task automatic wait_mod(input int m);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (n % 16 == m) return;
        end
        chk("wait_mod_timeout", 8'd1, 8'd0);
    endtask

    task automatic goto_slot(input int s);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (n > 0 && (n / 4) % 4 == s) return;
        end
        chk("goto_slot_timeout", 8'd1, 8'd0);
    endtask

    task automatic goto_fs(input int f, input int s);
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (n / 16 == f && (n / 4) % 4 == s) return;
        end
        chk("goto_fs_timeout", 8'd1, 8'd0);
    endtask

    task automatic wait_ack();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ack === 1'b1) return;
        end
        chk("ack_timeout", 8'd1, 8'd0);
    endtask

    initial begin
        int a0, nl;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset and idle
        wait_n(1);  chk("idle_an0", {4'b0, an}, 8'h01); chk("idle_seg", {1'b0, seg}, 8'h7F);
        wait_n(5);  chk("idle_an1", {4'b0, an}, 8'h02);
        wait_n(9);  chk("idle_an2", {4'b0, an}, 8'h04);
        wait_n(13); chk("idle_an3", {4'b0, an}, 8'h08);
        wait_n(16); chk("idle_frame", {7'b0, frame}, 8'h01);
        wait_n(50);
        chk("idle_frames3", 8'(frame_cnt), 8'd3);
        chk("idle_no_ack", 8'(ack_cnt), 8'd0);

        // Decimal load
        a0 = ack_cnt;
        do_load(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        wait_ack();
        chk("dec_slot0_4", {1'b0, seg}, {1'b0, 7'b0011001});
        goto_slot(3); chk("dec_slot3_1", {1'b0, seg}, {1'b0, 7'b1111001});
        chk("dec_one_ack", 8'(ack_cnt - a0), 8'd1);
        do_load(16'h00AF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        wait_ack();
        chk("dash_slot0", {1'b0, seg}, {1'b0, 7'b0111111});
        goto_slot(1); chk("dash_slot1", {1'b0, seg}, {1'b0, 7'b0111111});

        // Hex with leading-zero suppression
        do_load(16'h00A0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        wait_ack();
        chk("lzs_d0", {1'b0, seg}, {1'b0, 7'b1000000});
        goto_slot(1); chk("lzs_d1", {1'b0, seg}, {1'b0, 7'b0001000});
        goto_slot(2); chk("lzs_d2", {1'b0, seg}, 8'h7F);
        goto_slot(3); chk("lzs_d3", {1'b0, seg}, 8'h7F);

        // All-zero with suppression
        do_load(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        wait_ack();
        chk("zero_d0", {1'b0, seg}, {1'b0, 7'b1000000});
        goto_slot(1); chk("zero_d1", {1'b0, seg}, 8'h7F);
        goto_slot(3); chk("zero_d3", {1'b0, seg}, 8'h7F);

        // Two loads within one frame
        wait_mod(1);
        a0 = ack_cnt;
        do_load(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        do_load(16'h2222, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        wait_ack();
        chk("dbl_second_val", {1'b0, seg}, {1'b0, 7'b0100100});
        repeat (40) @(negedge clk);
        chk("dbl_single_ack", 8'(ack_cnt - a0), 8'd1);

        // Load on the boundary cycle
        wait_mod(15);
        d_data = 16'h5678; d_dp = 4'h0; d_blank = 4'h0; d_blink = 4'h0; d_hex = 1'b0; d_lzs = 1'b0;
        d_load = 1'b1;
        @(posedge clk); #1 d_load = 1'b0;
        nl = n;
        wait_ack();
        chk("bnd_latency", 8'(n - nl), 8'd16);
        chk("bnd_val", {1'b0, seg}, {1'b0, 7'b0000000});

        // Reset while pending
        wait_mod(1);
        do_load(16'h9999, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        a0 = ack_cnt;
        repeat (40) @(negedge clk);
        chk("rst_no_ack", 8'(ack_cnt - a0), 8'd0);
        chk("rst_dark", {1'b0, seg}, 8'h7F);

        // Blink and decimal point, frames counted from the reset above
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        do_load(16'h1234, 4'b0010, 4'h0, 4'b0001, 1'b0, 1'b0);
        wait_ack();
        chk("blk_ack_frame1", 8'(n), 8'd16);
        goto_fs(1, 0); chk("blk_f1_lit", {1'b0, seg}, {1'b0, 7'b0011001});
        chk("blk_f1_dpo0", {7'b0, dpo}, 8'h01);
        goto_fs(1, 1); chk("blk_f1_dpo1", {7'b0, dpo}, 8'h00);
        chk("blk_f1_seg1", {1'b0, seg}, {1'b0, 7'b0110000});
        goto_fs(2, 0); chk("blk_f2_dark", {1'b0, seg}, 8'h7F);
        goto_fs(3, 0); chk("blk_f3_dark", {1'b0, seg}, 8'h7F);
        goto_fs(3, 1); chk("blk_f3_dpo1", {7'b0, dpo}, 8'h00);
        goto_fs(4, 0); chk("blk_f4_lit", {1'b0, seg}, {1'b0, 7'b0011001});
        goto_fs(5, 0); chk("blk_f5_lit", {1'b0, seg}, {1'b0, 7'b0011001});

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
